// File: rtl/step_motor_sequencer.sv
// Stepper motor move sequencer: accepts a step/period command and walks the
// 8-entry coil phase table in half- or full-step increments, honouring end switches and abort.
module step_motor_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             MSE_SCLK,
    input  logic             MSE_RESETN,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic             cmd_half,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [CNT_W-1:0] cmd_period,
    input  logic             hold_en,
    input  logic             abort,
    input  logic             limit_pos,
    input  logic             limit_neg,
    output logic             busy,
    output logic             done,
    output logic             limit_hit,
    output logic [31:0]      position,
    output logic             AX,
    output logic             AY,
    output logic             BX,
    output logic             BY
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic             half_q, half_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       ph_q, ph_d;
    logic [31:0]      pos_q, pos_d;
    logic [3:0]       coil_q, coil_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             lim_q, lim_d;
    logic [2:0]       ph_inc;
    logic             limit_now;

    function automatic logic [3:0] ph_map(input logic [2:0] ph);
        logic [3:0] m;
        case (ph)
            3'd0:    m = 4'b1010;
            3'd1:    m = 4'b1000;
            3'd2:    m = 4'b1001;
            3'd3:    m = 4'b0001;
            3'd4:    m = 4'b0101;
            3'd5:    m = 4'b0100;
            3'd6:    m = 4'b0110;
            default: m = 4'b0010;
        endcase
        return m;
    endfunction

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        half_d    = half_q;
        rem_d     = rem_q;
        per_d     = per_q;
        cnt_d     = cnt_q;
        ph_d      = ph_q;
        pos_d     = pos_q;
        lim_d     = 1'b0;
        ph_inc    = half_q ? 3'd1 : 3'd2;
        limit_now = dir_q ? limit_pos : limit_neg;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    dir_d   = cmd_dir;
                    half_d  = cmd_half;
                    rem_d   = cmd_steps;
                    per_d   = (cmd_period == '0) ? ONE : cmd_period;
                    cnt_d   = per_d - ONE;
                    // Full-step moves run on even phases only
                    ph_d    = cmd_half ? ph_q : {ph_q[2:1], 1'b0};
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort || rem_q == '0) begin
                    state_d = S_DONE;
                end else if (cnt_q == '0) begin
                    if (limit_now) begin
                        state_d = S_DONE;
                        lim_d   = 1'b1;
                    end else begin
                        ph_d  = dir_q ? ph_q + ph_inc : ph_q - ph_inc;
                        pos_d = dir_q ? pos_q + 32'd1 : pos_q - 32'd1;
                        rem_d = rem_q - ONE;
                        cnt_d = per_q - ONE;
                        if (rem_q == ONE)
                            state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered off the next state so they line up with ph
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d == S_RUN);
        done_d  = (state_d == S_DONE);
        coil_d  = (state_d != S_IDLE || hold_en) ? ph_map(ph_d) : 4'b0000;
    end

    always_ff @(posedge MSE_SCLK) begin
        if (!MSE_RESETN) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
            half_q  <= 1'b0;
            rem_q   <= '0;
            per_q   <= '0;
            cnt_q   <= '0;
            ph_q    <= 3'd0;
            pos_q   <= 32'd0;
            coil_q  <= 4'b0000;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lim_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            half_q  <= half_d;
            rem_q   <= rem_d;
            per_q   <= per_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            pos_q   <= pos_d;
            coil_q  <= coil_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lim_q   <= lim_d;
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign limit_hit = lim_q;
    assign position  = pos_q;
    assign AX        = coil_q[3];
    assign AY        = coil_q[2];
    assign BX        = coil_q[1];
    assign BY        = coil_q[0];

endmodule

// File: tb/tb_step_motor_sequencer.sv
// Directed bench for step_motor_sequencer: expected step/done events are queued
// at command issue and matched against position changes and done pulses.
module tb_step_motor_sequencer;

    logic        MSE_SCLK = 1'b0;
    logic        MSE_RESETN;
    logic        cmd_valid, cmd_ready, cmd_dir, cmd_half;
    logic [15:0] cmd_steps, cmd_period;
    logic        hold_en, abort, limit_pos, limit_neg;
    logic        busy, done, limit_hit;
    logic [31:0] position;
    logic        AX, AY, BX, BY;

    typedef struct {
        int          cyc;
        logic [3:0]  coil;
        logic [31:0] pos;
        logic        dn;
        logic        lim;
    } ev_t;

    ev_t         sbq[$];
    logic [3:0]  MAP [8] = '{4'b1010, 4'b1000, 4'b1001, 4'b0001,
                             4'b0101, 4'b0100, 4'b0110, 4'b0010};
    logic [2:0]  mph = 3'd0;
    logic [31:0] mpos = 32'd0;
    logic [31:0] prev_pos = 32'd0;
    logic        mon_en = 1'b0;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          a;

    step_motor_sequencer #(.CNT_W(16)) dut (
        .MSE_SCLK(MSE_SCLK), .MSE_RESETN(MSE_RESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_half(cmd_half), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
        .hold_en(hold_en), .abort(abort), .limit_pos(limit_pos), .limit_neg(limit_neg),
        .busy(busy), .done(done), .limit_hit(limit_hit), .position(position),
        .AX(AX), .AY(AY), .BX(BX), .BY(BY)
    );

    always #5 MSE_SCLK = ~MSE_SCLK;
    always @(posedge MSE_SCLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] coils();
        return {AX, AY, BX, BY};
    endfunction

    task automatic monitor();
        ev_t e;
        forever begin
            @(negedge MSE_SCLK);
            if (mon_en && (position !== prev_pos || done === 1'b1)) begin
                chk("event_expected", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("ev_cycle", 32'(cyc), 32'(e.cyc));
                    chk("ev_coils", 32'(coils()), 32'(e.coil));
                    chk("ev_position", position, e.pos);
                    chk("ev_done", 32'(done), 32'(e.dn));
                    chk("ev_limit_hit", 32'(limit_hit), 32'(e.lim));
                    if (e.dn) chk("ready_in_done", 32'(cmd_ready), 32'd0);
                end
            end
            prev_pos = position;
        end
    endtask

    // kind: 0 = runs to completion, 1 = stopped by limit after 'take' steps, 2 = aborted after 'take'
    task automatic issue(input logic dir, input logic half, input int steps, input int period,
                         input int take, input int kind, output int acc);
        int p, n;
        logic [2:0] ph0;
        ev_t e;
        p   = (period == 0) ? 1 : period;
        acc = cyc + 1;
        if (!half) mph[0] = 1'b0;
        ph0 = mph;
        n   = (kind == 0) ? steps : take;
        for (int k = 1; k <= n; k++) begin
            mph  = dir ? mph + (half ? 3'd1 : 3'd2) : mph - (half ? 3'd1 : 3'd2);
            mpos = dir ? mpos + 32'd1 : mpos - 32'd1;
            e = '{acc + k * p, MAP[mph], mpos, (kind == 0 && k == steps), 1'b0};
            sbq.push_back(e);
        end
        if (kind == 0 && steps == 0) begin
            e = '{acc + 1, MAP[mph], mpos, 1'b1, 1'b0};
            sbq.push_back(e);
        end else if (kind != 0) begin
            e = '{acc + (n + 1) * p, MAP[mph], mpos, 1'b1, (kind == 1)};
            sbq.push_back(e);
        end
        cmd_dir = dir; cmd_half = half;
        cmd_steps = 16'(steps); cmd_period = 16'(period);
        cmd_valid = 1'b1;
        @(posedge MSE_SCLK);
        @(negedge MSE_SCLK);
        cmd_valid = 1'b0;
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_ready", 32'(cmd_ready), 32'd0);
        chk("accept_coils", 32'(coils()), 32'(MAP[ph0]));
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400 && !(sbq.size() == 0 && cmd_ready === 1'b1); i++)
            @(negedge MSE_SCLK);
        chk(tag, 32'(sbq.size()), 32'd0);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        MSE_RESETN = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_half = 1'b0;
        cmd_steps = '0; cmd_period = '0; hold_en = 1'b0; abort = 1'b0;
        limit_pos = 1'b0; limit_neg = 1'b0;
        fork monitor(); join_none
        repeat (3) @(negedge MSE_SCLK);
        chk("rst_coils", 32'(coils()), 32'd0);
        chk("rst_position", position, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_limit_hit", 32'(limit_hit), 32'd0);
        MSE_RESETN = 1'b1;
        @(negedge MSE_SCLK);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        mon_en = 1'b1;

        // half-step forward 3 x 4
        issue(1'b1, 1'b1, 3, 4, 0, 0, a);
        wait_idle("half_fwd");
        chk("idle_nohold_coils", 32'(coils()), 32'd0);

        // full-step reverse from ph 3: cleared to 2, then 0, 6
        issue(1'b0, 1'b0, 2, 2, 0, 0, a);
        wait_idle("full_rev");

        // forward limit before 4th step; limit_neg is ignored going forward
        limit_neg = 1'b1;
        issue(1'b1, 1'b1, 10, 3, 3, 1, a);
        while (cyc < a + 10) @(negedge MSE_SCLK);
        limit_pos = 1'b1;
        wait_idle("limit");
        limit_pos = 1'b0; limit_neg = 1'b0;

        // abort coinciding with the 2nd due step
        issue(1'b0, 1'b0, 5, 2, 1, 2, a);
        while (cyc < a + 3) @(negedge MSE_SCLK);
        abort = 1'b1;
        @(negedge MSE_SCLK);
        abort = 1'b0;
        chk("abort_done_pulse", 32'(done), 32'd1);
        @(negedge MSE_SCLK);
        chk("abort_ready_after", 32'(cmd_ready), 32'd1);
        wait_idle("abort");

        // zero steps, then zero period
        issue(1'b1, 1'b1, 0, 7, 0, 0, a);
        wait_idle("zero_steps");
        issue(1'b1, 1'b1, 2, 0, 0, 0, a);
        wait_idle("zero_period");

        // reset mid-move: abandoned with no done pulse
        issue(1'b1, 1'b1, 10, 5, 0, 0, a);
        while (cyc < a + 7) @(negedge MSE_SCLK);
        mon_en = 1'b0;
        MSE_RESETN = 1'b0;
        @(negedge MSE_SCLK);
        chk("midrst_position", position, 32'd0);
        chk("midrst_coils", 32'(coils()), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        MSE_RESETN = 1'b1;
        @(negedge MSE_SCLK);
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        begin
            logic saw_done = 1'b0;
            repeat (4) begin
                @(negedge MSE_SCLK);
                saw_done |= done;
            end
            chk("midrst_no_done", 32'(saw_done), 32'd0);
        end
        sbq.delete();
        mph = 3'd0; mpos = 32'd0;
        mon_en = 1'b1;

        // hold_en toggling in IDLE
        hold_en = 1'b1;
        @(negedge MSE_SCLK);
        chk("hold_on_coils", 32'(coils()), 32'(MAP[mph]));
        hold_en = 1'b0;
        @(negedge MSE_SCLK);
        chk("hold_off_coils", 32'(coils()), 32'd0);

        // hold on after a move keeps the last phase
        hold_en = 1'b1;
        issue(1'b0, 1'b1, 1, 1, 0, 0, a);
        wait_idle("hold_move");
        chk("hold_after_move", 32'(coils()), 32'(MAP[mph]));
        chk("final_position", position, mpos);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/step_motor_sequencer.md
STEP_MOTOR_SEQUENCER -- requirements
Module: step_motor_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, the width of the step-count and step-period fields.
REQ-002 SHALL have port MSE_SCLK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port MSE_RESETN, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port cmd_valid, input, 1 bit: move command present.
REQ-005 SHALL have port cmd_ready, output, 1 bit: high only in IDLE.
REQ-006 SHALL have port cmd_dir, input, 1 bit: 1 = forward (phase index +), 0 = reverse.
REQ-007 SHALL have port cmd_half, input, 1 bit: 1 = half-step mode, 0 = full-step mode.
REQ-008 SHALL have port cmd_steps, input, CNT_W bits: number of steps to issue.
REQ-009 SHALL have port cmd_period, input, CNT_W bits: clocks per step.
REQ-010 SHALL have port hold_en, input, 1 bit: keep the coils energised while IDLE.
REQ-011 SHALL have port abort, input, 1 bit: terminate the move in progress.
REQ-012 SHALL have ports limit_pos and limit_neg, inputs, 1 bit each: active-high end switches.
REQ-013 SHALL have port busy, output, 1 bit: high in RUN.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a move.
REQ-015 SHALL have port limit_hit, output, 1 bit: one-cycle pulse, concurrent with done, when a move stopped on a limit.
REQ-016 SHALL have port position, output, 32 bits: signed step counter.
REQ-017 SHALL have ports AX, AY, BX, BY, outputs, 1 bit each: coil phase drive.

Function
REQ-018 SHALL implement the states IDLE, RUN and DONE.
REQ-019 SHALL accept a command on the cycle that cmd_valid and cmd_ready are both high, latching dir, half, steps and period (period 0 treated as 1), and go to RUN.
REQ-020 SHALL use a 3-bit phase index ph whose {AX,AY,BX,BY} map is: 0=1010, 1=1000, 2=1001, 3=0001, 4=0101, 5=0100, 6=0110, 7=0010.
REQ-021 SHALL, when a full-step command is accepted, clear ph[0] on the accept edge; this is not counted as a step and does not change position.
REQ-022 SHALL, in RUN, use a period counter so that step k (k = 1..N) occurs exactly k*P cycles after the accept edge.
REQ-023 SHALL, on each step, change ph by +/-1 in half-step mode or +/-2 in full-step mode (mod 8), change position by +/-1 (32-bit wrap), and decrement the remaining count.
REQ-024 SHALL present AX..BY registered from ph, updating on the same edge as ph.
REQ-025 SHALL, when a command with cmd_steps = 0 is accepted, go RUN -> DONE on the next edge with no step.
REQ-026 SHALL go to DONE on the edge of the final step.
REQ-027 SHALL, when a step is due and the limit for the current direction (limit_pos for forward, limit_neg for reverse) is high, suppress that step and go to DONE with limit_hit.
REQ-028 SHALL, when abort is high in RUN, go to DONE on the next edge with no further step; abort takes priority over a step due in the same cycle.
REQ-029 SHALL spend exactly one cycle in DONE, asserting done (and limit_hit when applicable), then return to IDLE.
REQ-030 SHALL, in IDLE, keep ph unchanged; the outputs SHALL follow the ph map when hold_en = 1 and SHALL be 0000 when hold_en = 0.
REQ-031 SHALL drive the ph map on the outputs in RUN and DONE regardless of hold_en.
REQ-032 SHALL ignore abort outside RUN, and SHALL ignore the limit inputs other than at step times.

Reset
REQ-033 SHALL, on MSE_RESETN = 0 at a clock edge, set state = IDLE, ph = 0, position = 0, counters = 0, busy = done = limit_hit = 0, and AX..BY = 0000.
REQ-034 SHALL then assert cmd_ready = 1 on the first cycle after reset is released.
REQ-035 SHALL, if reset occurs mid-move, abandon the move with no done pulse.

Verification
REQ-036 Half-step forward: steps = 3, period = 4, ph = 0 -> ph 1, 2, 3 at accept +4, +8, +12 cycles; done at +12; position = 3; outputs 0001.
REQ-037 Full-step reverse from ph = 3: steps = 2, period = 2 -> ph cleared to 2 at accept, then ph 0 at +2 and ph 6 at +4; position = -2.
REQ-038 Limit: forward, steps = 10, limit_pos raised before the 4th step -> exactly 3 steps, done and limit_hit pulses at 4*P, position = 3.
REQ-039 Abort in the same cycle as a due step -> no step, done pulse on the next edge, cmd_ready high the cycle after.
REQ-040 Zero cases: steps = 0 -> done 1 cycle after accept, position unchanged; period = 0 with steps = 2 -> steps at +1 and +2.
REQ-041 Reset mid-move and the hold_en idle behaviour: outputs 0000 with position 0; toggling hold_en in IDLE switches the outputs between the map value and 0000.
